uart_tx_result_sequencer: RTL and testbench

Sequences the 32-bit adder result and carry-out onto the serial line through the existing UART transmitter (Tx_DV/Tx_Byte/Tx_Active/Tx_Done interface). On a start request it latches the operands and emits a fixed 7-byte frame. The frame is a header, the result MSB-first, a flags byte and an XOR checksum, sent one byte at a time with a per-byte watchdog. It sits between the adder datapath and the UART transmitter and is the transmitter's only client.

---
 rtl/uart_tx_result_sequencer_if.sv | 23 ++
 rtl/uart_tx_result_sequencer.sv | 157 +++++++++++++++
 tb/tb_uart_tx_result_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_result_sequencer_if.sv
// Handshake bundle between the adder-side requester, the result sequencer and the UART transmitter.
interface uart_tx_result_sequencer_if;
    logic        Start_in;
    logic [31:0] Result_in;
    logic        Carry_in;
    logic        Tx_Active_in;
    logic        Tx_Done_in;
    logic        Tx_DV_out;
    logic [7:0]  Tx_Byte_out;
    logic        Busy_out;
    logic        Done_out;
    logic        Error_out;

    modport slave (
        input  Start_in, Result_in, Carry_in, Tx_Active_in, Tx_Done_in,
        output Tx_DV_out, Tx_Byte_out, Busy_out, Done_out, Error_out
    );

    modport master (
        output Start_in, Result_in, Carry_in, Tx_Active_in, Tx_Done_in,
        input  Tx_DV_out, Tx_Byte_out, Busy_out, Done_out, Error_out
    );
endinterface

// File: rtl/uart_tx_result_sequencer.sv
// Sends a 7-byte frame (header, result MSB-first, flags, XOR checksum) through the UART transmitter,
// one byte per Tx_DV pulse, with a per-byte watchdog on Tx_Done.
//
// state   | meaning
// S_IDLE  | waiting for Start_in with the transmitter inactive
// S_SEND  | Tx_DV_out pulse for the current byte
// S_WAIT  | waiting for Tx_Done_in, watchdog running
// S_DONE  | Done_out pulse, frame complete
// S_ERROR | Error_out pulse, frame abandoned on watchdog expiry
module uart_tx_result_sequencer #(
    parameter logic [7:0] HEADER_BYTE  = 8'hA5,
    parameter int         CLKS_PER_BIT = 234,
    parameter int         TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input logic                        CLK,
    input logic                        RST_N_in,
    uart_tx_result_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
    localparam logic [2:0]  LAST_IDX     = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic [7:0]  chk_q, chk_d;
    logic        dv_q, dv_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [31:0] r,
                                              input logic c, input logic [7:0] chk);
        logic [7:0] b;
        case (i)
            3'd0:    b = HEADER_BYTE;
            3'd1:    b = r[31:24];
            3'd2:    b = r[23:16];
            3'd3:    b = r[15:8];
            3'd4:    b = r[7:0];
            3'd5:    b = {7'b0, c};
            3'd6:    b = chk;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        chk_d    = chk_q;
        dv_d     = 1'b0;
        byte_d   = byte_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.Start_in && !bus.Tx_Active_in) begin
                    result_d = bus.Result_in;
                    carry_d  = bus.Carry_in;
                    // Checksum taken from the operands being latched, so later input changes cannot leak in
                    chk_d    = bus.Result_in[31:24] ^ bus.Result_in[23:16] ^ bus.Result_in[15:8]
                             ^ bus.Result_in[7:0] ^ {7'b0, bus.Carry_in};
                    idx_d    = 3'd0;
                    busy_d   = 1'b1;
                    dv_d     = 1'b1;
                    byte_d   = HEADER_BYTE;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.Tx_Done_in) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        dv_d    = 1'b1;
                        byte_d  = frame_byte(idx_q + 3'd1, result_q, carry_q, chk_q);
                        state_d = S_SEND;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE, S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                cnt_d   = 16'd0;
                byte_d  = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N_in) begin
        if (!RST_N_in) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= 16'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            chk_q    <= 8'h00;
            dv_q     <= 1'b0;
            byte_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            chk_q    <= chk_d;
            dv_q     <= dv_d;
            byte_q   <= byte_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.Tx_DV_out   = dv_q;
    assign bus.Tx_Byte_out = byte_q;
    assign bus.Busy_out    = busy_q;
    assign bus.Done_out    = done_q;
    assign bus.Error_out   = err_q;
endmodule

// File: tb/tb_uart_tx_result_sequencer.sv
// Bench for the UART result sequencer: behavioural transmitter stub, frame scoreboard, timing monitor.
`timescale 1ns/1ps
module tb_uart_tx_result_sequencer;
    localparam int TMO = 50;

    logic CLK = 1'b0;
    logic RST_N_in = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_result_sequencer_if bus();

    uart_tx_result_sequencer #(
        .HEADER_BYTE (8'hA5),
        .CLKS_PER_BIT(4),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .CLK     (CLK),
        .RST_N_in(RST_N_in),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Transmitter stub: Tx_Active while a byte is in flight, Tx_Done pulse stub_lat cycles after DV
    logic       stub_active = 1'b0;
    logic       stub_done   = 1'b0;
    logic       hold_active = 1'b0;
    bit         stub_busy   = 1'b0;
    int         stub_lat    = 40;
    int         stub_cnt    = 0;
    int         hang_pos    = -1;
    int         cur_pos     = 0;
    logic [7:0] cur_byte    = 8'h00;
    logic [7:0] rx[$];
    int         collisions  = 0;
    int         unstable    = 0;

    assign bus.Tx_Active_in = stub_active | hold_active;
    assign bus.Tx_Done_in   = stub_done;

    always begin
        @(posedge CLK); #1;
        stub_done = 1'b0;
        if (stub_busy) begin
            if (bus.Tx_DV_out) collisions++;
            if (cur_pos != hang_pos) stub_cnt++;
            if (stub_cnt >= stub_lat) begin
                if (bus.Busy_out && bus.Tx_Byte_out !== cur_byte) unstable++;
                stub_done   = 1'b1;
                stub_active = 1'b0;
                stub_busy   = 1'b0;
            end
        end else if (bus.Tx_DV_out) begin
            cur_byte = bus.Tx_Byte_out;
            rx.push_back(cur_byte);
            cur_pos     = rx.size() - 1;
            stub_busy   = 1'b1;
            stub_cnt    = 0;
            stub_active = 1'b1;
        end
    end

    int cyc = 0, dv_cnt = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, busy_gap = 0;
    bit in_frame = 1'b0;
    int dv_cyc[$];

    always begin
        @(posedge CLK); #1;
        cyc++;
        if (!RST_N_in) begin
            in_frame = 1'b0;
        end else begin
            if (bus.Tx_DV_out) begin dv_cnt++; dv_cyc.push_back(cyc); in_frame = 1'b1; end
            if (bus.Done_out)  begin done_cnt++; in_frame = 1'b0; end
            if (bus.Error_out) begin err_cnt++; err_cyc = cyc; in_frame = 1'b0; end
            if (in_frame && !bus.Busy_out) busy_gap++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [7:0] model_byte(input logic [31:0] r, input logic c, input int i);
        logic [7:0] f [7];
        f[0] = 8'hA5;
        for (int k = 1; k <= 4; k++) f[k] = 8'((r >> (8 * (4 - k))) & 32'hFF);
        f[5] = {7'b0, c};
        f[6] = 8'h00;
        for (int k = 1; k <= 5; k++) f[6] = f[6] ^ f[k];
        return f[i];
    endfunction

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int base;
        base = done_cnt + err_cnt;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge CLK); #2;
            if (done_cnt + err_cnt >= base + n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_quiet(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #2;
            if (!stub_busy && !stub_done && !bus.Busy_out && !bus.Done_out && !bus.Error_out) begin
                ok = 1'b1; break;
            end
        end
        @(posedge CLK); #2;
    endtask

    task automatic start_frame(input logic [31:0] r, input logic c, output bit ok);
        bus.Result_in = r;
        bus.Carry_in  = c;
        bus.Start_in  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #2;
            if (bus.Busy_out) begin ok = 1'b1; break; end
        end
        bus.Start_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.Start_in  = 1'b0;
        bus.Result_in = 32'h0;
        bus.Carry_in  = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        checks++; if (bus.Tx_DV_out !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", bus.Tx_DV_out); end
        checks++; if (bus.Tx_Byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", bus.Tx_Byte_out); end
        checks++; if (bus.Busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy_out); end
        checks++; if (bus.Done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.Done_out); end
        checks++; if (bus.Error_out !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.Error_out); end
        RST_N_in = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
    endtask

    task automatic run_directed(input string name, input logic [31:0] r, input logic c,
                                input logic [7:0] want [7], input bit scramble);
        int base_rx, d0, e0, v0, g0;
        bit ok;
        base_rx = rx.size(); d0 = done_cnt; e0 = err_cnt; v0 = dv_cnt; g0 = busy_gap;
        start_frame(r, c, ok);
        if (scramble) begin bus.Result_in = $urandom; bus.Carry_in = ~c; end
        if (ok) wait_frames(1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_complete: got timeout want frame end", name); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx.size() <= base_rx + i || rx[base_rx + i] !== want[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i,
                         (rx.size() > base_rx + i) ? rx[base_rx + i] : 8'hxx, want[i]);
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt - d0); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL %s_error_pulses: got %0d want 0", name, err_cnt - e0); end
        checks++; if (dv_cnt - v0 != 7) begin errors++; $display("FAIL %s_dv_pulses: got %0d want 7", name, dv_cnt - v0); end
        checks++; if (busy_gap != g0) begin errors++; $display("FAIL %s_busy_gap: got %0d want 0", name, busy_gap - g0); end
        wait_quiet(ok);
    endtask

    task automatic test_basic();
        logic [7:0] want [7];
        want = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h08};
        stub_lat = 40;
        run_directed("basic", 32'h12345678, 1'b0, want, 1'b0);
    endtask

    task automatic test_all_ones_midchange();
        logic [7:0] want [7];
        want = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
        stub_lat = 40;
        run_directed("ones", 32'hFFFFFFFF, 1'b1, want, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic c;
        int base_rx, d0, e0;
        bit ok;
        for (int f = 0; f < 6; f++) begin
            r = $urandom; c = 1'($urandom_range(1, 0));
            stub_lat = $urandom_range(49, 1);
            base_rx = rx.size(); d0 = done_cnt; e0 = err_cnt;
            start_frame(r, c, ok);
            if (ok) wait_frames(1, 2000, ok);
            checks++; if (!ok || done_cnt - d0 != 1 || err_cnt != e0) begin
                errors++; $display("FAIL random%0d_end: got done=%0d err=%0d want done=1 err=0", f, done_cnt - d0, err_cnt - e0);
            end
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx.size() <= base_rx + i || rx[base_rx + i] !== model_byte(r, c, i)) begin
                    errors++;
                    $display("FAIL random%0d_byte%0d: got %h want %h", f, i,
                             (rx.size() > base_rx + i) ? rx[base_rx + i] : 8'hxx, model_byte(r, c, i));
                end
            end
            wait_quiet(ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int base_rx, d0, v0, e0;
        bit ok;
        r = $urandom;
        stub_lat = 20;
        base_rx = rx.size(); d0 = done_cnt; v0 = dv_cnt; e0 = err_cnt;
        bus.Result_in = r; bus.Carry_in = 1'b1; bus.Start_in = 1'b1;
        wait_frames(3, 3000, ok);
        bus.Start_in = 1'b0;
        checks++; if (!ok || done_cnt - d0 != 3) begin errors++; $display("FAIL b2b_frames: got %0d want 3", done_cnt - d0); end
        checks++; if (dv_cnt - v0 != 21) begin errors++; $display("FAIL b2b_dv_pulses: got %0d want 21", dv_cnt - v0); end
        checks++; if (collisions != 0) begin errors++; $display("FAIL b2b_dv_while_active: got %0d want 0", collisions); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL b2b_errors: got %0d want 0", err_cnt - e0); end
        for (int i = 0; i < 21; i++) begin
            checks++;
            if (rx.size() <= base_rx + i || rx[base_rx + i] !== model_byte(r, 1'b1, i % 7)) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h want %h", i,
                         (rx.size() > base_rx + i) ? rx[base_rx + i] : 8'hxx, model_byte(r, 1'b1, i % 7));
            end
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL byte_stable_during_wait: got %0d changes want 0", unstable); end
        wait_quiet(ok);
    endtask

    task automatic test_timeout();
        int base_rx, base_dv, d0, e0, v0;
        bit ok;
        stub_lat = 10;
        base_rx = rx.size(); base_dv = dv_cyc.size(); d0 = done_cnt; e0 = err_cnt; v0 = dv_cnt;
        hang_pos = base_rx + 2;
        start_frame($urandom, 1'b0, ok);
        if (ok) wait_frames(1, 2000, ok);
        checks++; if (!ok || err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_error_pulse: got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt - d0); end
        checks++; if (dv_cnt - v0 != 3) begin errors++; $display("FAIL timeout_dv_pulses: got %0d want 3", dv_cnt - v0); end
        checks++;
        if (dv_cyc.size() < base_dv + 3 || err_cyc - dv_cyc[base_dv + 2] != TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d want %0d cycles after third DV",
                     (dv_cyc.size() >= base_dv + 3) ? err_cyc - dv_cyc[base_dv + 2] : -1, TMO + 1);
        end
        checks++; if (bus.Busy_out !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", bus.Busy_out); end
        hang_pos = -1;
        wait_quiet(ok);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int v0, base_rx;
        bit ok;
        stub_lat = 40;
        v0 = dv_cnt;
        start_frame($urandom, 1'b1, ok);
        for (int k = 0; k < 1000 && dv_cnt < v0 + 4; k++) begin @(posedge CLK); #2; end
        repeat (5) @(posedge CLK);
        #4;
        RST_N_in = 1'b0;
        #1;
        checks++;
        if ({bus.Tx_DV_out, bus.Busy_out, bus.Done_out, bus.Error_out, bus.Tx_Byte_out} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got dv=%b busy=%b done=%b err=%b byte=%h want all 0",
                     bus.Tx_DV_out, bus.Busy_out, bus.Done_out, bus.Error_out, bus.Tx_Byte_out);
        end
        hold_active = 1'b1;
        r = $urandom;
        bus.Result_in = r; bus.Carry_in = 1'b0; bus.Start_in = 1'b1;
        @(posedge CLK); @(posedge CLK); #2;
        RST_N_in = 1'b1;
        v0 = dv_cnt;
        repeat (5) @(posedge CLK);
        #2;
        checks++; if (bus.Busy_out !== 1'b0 || dv_cnt != v0) begin
            errors++; $display("FAIL start_while_active: got busy=%b dv=%0d want busy=0 dv=0", bus.Busy_out, dv_cnt - v0);
        end
        for (int k = 0; k < 200 && (stub_busy || stub_done); k++) begin @(posedge CLK); #2; end
        base_rx = rx.size();
        hold_active = 1'b0;
        @(posedge CLK); #2;
        checks++; if (bus.Tx_DV_out !== 1'b1 || bus.Busy_out !== 1'b1 || bus.Tx_Byte_out !== 8'hA5) begin
            errors++; $display("FAIL accept_when_inactive: got dv=%b busy=%b byte=%h want 1 1 a5",
                               bus.Tx_DV_out, bus.Busy_out, bus.Tx_Byte_out);
        end
        bus.Start_in = 1'b0;
        wait_frames(1, 2000, ok);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (!ok || rx.size() <= base_rx + i || rx[base_rx + i] !== model_byte(r, 1'b0, i)) begin
                errors++;
                $display("FAIL post_reset_byte%0d: got %h want %h", i,
                         (rx.size() > base_rx + i) ? rx[base_rx + i] : 8'hxx, model_byte(r, 1'b0, i));
            end
        end
        wait_quiet(ok);
    endtask

    task automatic test_done_at_timeout();
        logic [31:0] r;
        int base_rx, d0, e0, v0;
        bit ok;
        r = $urandom;
        stub_lat = TMO;
        base_rx = rx.size(); d0 = done_cnt; e0 = err_cnt;
        start_frame(r, 1'b1, ok);
        if (ok) wait_frames(1, 3000, ok);
        checks++; if (!ok || done_cnt - d0 != 1 || err_cnt != e0) begin
            errors++; $display("FAIL done_wins: got done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx.size() <= base_rx + i || rx[base_rx + i] !== model_byte(r, 1'b1, i)) begin
                errors++;
                $display("FAIL done_wins_byte%0d: got %h want %h", i,
                         (rx.size() > base_rx + i) ? rx[base_rx + i] : 8'hxx, model_byte(r, 1'b1, i));
            end
        end
        wait_quiet(ok);
        stub_lat = TMO + 1;
        d0 = done_cnt; e0 = err_cnt; v0 = dv_cnt;
        start_frame($urandom, 1'b0, ok);
        if (ok) wait_frames(1, 2000, ok);
        checks++; if (!ok || err_cnt - e0 != 1 || done_cnt != d0 || dv_cnt - v0 != 1) begin
            errors++; $display("FAIL done_too_late: got err=%0d done=%0d dv=%0d want 1 0 1",
                               err_cnt - e0, done_cnt - d0, dv_cnt - v0);
        end
        wait_quiet(ok);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones_midchange();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        test_done_at_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
